// File: rtl/ofdm_ctrl_pkg.sv
// Shared OFDM transmit-control definitions: scheduler states and default frame geometry.
package ofdm_ctrl_pkg;

    localparam int OFDM_N_FFT          = 64;
    localparam int OFDM_CP_LEN         = 16;
    localparam int OFDM_SYMS_PER_FRAME = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_GAP,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/ofdm_sym_sched.sv
// Symbol scheduler: reads one N_FFT-sample symbol per burst from the staging buffer
// into the IFFT, spacing bursts by GAP idle cycles and tracking frame progress.
module ofdm_sym_sched
    import ofdm_ctrl_pkg::*;
#(
    parameter int N_FFT = OFDM_N_FFT,
    parameter int GAP   = OFDM_CP_LEN,
    parameter int SYMS  = OFDM_SYMS_PER_FRAME
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic                                       i_frame_start,
    input  logic                                       i_abort,
    input  logic                                       i_sym_ready,
    output logic                                       o_rd_en,
    output logic [$clog2(N_FFT)-1:0]                   o_rd_addr,
    output logic                                       o_ifft_di_en,
    output logic [((SYMS > 1) ? $clog2(SYMS) : 1)-1:0] o_sym_idx,
    output logic                                       o_frame_busy,
    output logic                                       o_frame_done,
    output logic                                       o_underrun
);

    localparam int AW = $clog2(N_FFT);
    localparam int SW = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [AW-1:0] ADDR_LAST = AW'(N_FFT - 1);
    localparam logic [SW-1:0] SYM_LAST  = SW'(SYMS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);

    sched_state_t  r_state, w_next;
    logic [AW-1:0] r_rd_addr, w_rd_addr;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt;
    logic [SW-1:0] r_sym_idx, w_sym_idx;
    logic          r_underrun, w_underrun;
    logic          r_rd_en;
    logic          r_ifft_di_en;
    logic          r_frame_busy;
    logic          r_frame_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_rd_addr  = r_rd_addr;
        w_gap_cnt  = r_gap_cnt;
        w_sym_idx  = r_sym_idx;
        w_underrun = r_underrun;
        // abort outranks every other input; underrun and sym_idx are left as they are
        if (i_abort) begin
            w_next    = ST_IDLE;
            w_rd_addr = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        w_next     = ST_WAIT;
                        w_sym_idx  = '0;
                        w_underrun = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_sym_ready) begin
                        w_next    = ST_READ;
                        w_rd_addr = '0;
                    end else if (r_sym_idx != '0) begin
                        w_underrun = 1'b1;
                    end
                end
                ST_READ: begin
                    w_rd_addr = r_rd_addr + 1'b1;
                    if (r_rd_addr == ADDR_LAST) begin
                        if (r_sym_idx == SYM_LAST) begin
                            w_next = ST_DONE;
                        end else if (GAP > 0) begin
                            w_next    = ST_GAP;
                            w_gap_cnt = '0;
                        end else begin
                            w_next    = ST_WAIT;
                            w_sym_idx = r_sym_idx + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                    if (r_gap_cnt == GAP_LAST) begin
                        w_next    = ST_WAIT;
                        w_sym_idx = r_sym_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_next = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_addr    <= '0;
            r_gap_cnt    <= '0;
            r_sym_idx    <= '0;
            r_underrun   <= 1'b0;
            r_rd_en      <= 1'b0;
            r_ifft_di_en <= 1'b0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_addr    <= w_rd_addr;
            r_gap_cnt    <= w_gap_cnt;
            r_sym_idx    <= w_sym_idx;
            r_underrun   <= w_underrun;
            r_rd_en      <= (w_next == ST_READ);
            r_ifft_di_en <= r_rd_en && !i_abort;
            r_frame_busy <= (w_next != ST_IDLE);
            r_frame_done <= (w_next == ST_DONE);
        end
    end

    assign o_rd_en      = r_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_ifft_di_en = r_ifft_di_en;
    assign o_sym_idx    = r_sym_idx;
    assign o_frame_busy = r_frame_busy;
    assign o_frame_done = r_frame_done;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// Bench for ofdm_sym_sched: table vectors, directed frames and randomized sym_ready
// patterns checked against a burst-schedule reference model.
module tb_ofdm_sym_sched;

    localparam int N    = 64;
    localparam int G    = 16;
    localparam int S    = 8;
    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       reset, fs, ab, sr;
    logic       rd_en, di_en, busy, done, und;
    logic [5:0] rd_addr;
    logic [2:0] sym_idx;

    logic       fs2;
    logic       sr2 = 1'b1;
    logic       ab2 = 1'b0;
    logic       rd_en2, di_en2, busy2, done2, und2;
    logic [5:0] rd_addr2;
    logic [0:0] sym_idx2;

    always #5 clk = ~clk;

    ofdm_sym_sched #(.N_FFT(N), .GAP(G), .SYMS(S)) dut (
        .i_clk(clk), .i_reset(reset), .i_frame_start(fs), .i_abort(ab), .i_sym_ready(sr),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_ifft_di_en(di_en), .o_sym_idx(sym_idx),
        .o_frame_busy(busy), .o_frame_done(done), .o_underrun(und)
    );

    ofdm_sym_sched #(.N_FFT(N), .GAP(0), .SYMS(1)) dut_short (
        .i_clk(clk), .i_reset(reset), .i_frame_start(fs2), .i_abort(ab2), .i_sym_ready(sr2),
        .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .o_ifft_di_en(di_en2), .o_sym_idx(sym_idx2),
        .o_frame_busy(busy2), .o_frame_done(done2), .o_underrun(und2)
    );

    int total = 0;
    int bad   = 0;

    bit ready_q [MAXC];
    bit e_rd    [MAXC];
    int e_addr  [MAXC];
    int e_sym   [MAXC];
    bit e_busy  [MAXC];
    bit e_done  [MAXC];
    bit e_und   [MAXC];
    int done_c;
    int obs_start [16];
    int nb;
    int obs_done;

    typedef struct {
        bit fs, ab, sr;
        bit e_busy, e_rd, e_di;
        int e_addr;
        bit e_done, e_und;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // mode 0: always ready; 1: ready dropped 10 cycles before burst 3; 2: random
    task automatic fill_ready(input int mode);
        for (int c = 0; c < MAXC; c++) begin
            if (mode == 2 && c < 800) ready_q[c] = ($urandom_range(0, 3) != 0);
            else                      ready_q[c] = 1'b1;
        end
        if (mode == 1)
            for (int c = 244; c < 254; c++) ready_q[c] = 1'b0;
    endtask

    // Schedule each symbol: wait for ready, burst of N, then gap; cycle 1 is the first WAIT.
    task automatic model_frame();
        int cur, st, ws, starve, stop;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_addr[c] = 0; e_sym[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_und[c] = 0;
        end
        cur    = 1;
        starve = MAXC;
        st     = 0;
        for (int k = 0; k < S; k++) begin
            ws = cur;
            while (!ready_q[cur] && cur < MAXC - 200) begin
                if (k > 0 && starve == MAXC) starve = cur;
                cur++;
            end
            st = cur + 1;
            for (int j = 0; j < N; j++) begin
                e_rd[st + j]   = 1;
                e_addr[st + j] = j;
            end
            stop = (k == S - 1) ? MAXC : st + N + G;
            for (int c = ws; c < stop; c++) e_sym[c] = k;
            cur = st + N + G;
        end
        done_c = st + N;
        e_done[done_c] = 1;
        for (int c = 1; c <= done_c; c++) e_busy[c] = 1;
        for (int c = starve + 1; c < MAXC; c++) e_und[c] = 1;
    endtask

    task automatic run_frame(input int kill_c, input bit kill_rst, input bit noise);
        int  end_c, lim;
        bit  killed, prev_rd;
        model_frame();
        end_c = (kill_c > 0) ? kill_c + 20 : done_c + 3;
        lim   = (kill_c > 0 && kill_c < done_c) ? kill_c : done_c;
        nb = 0; obs_done = 0; prev_rd = 0;
        fs = 1'b1; ab = 1'b0; sr = 1'($urandom);
        @(posedge clk); #1;
        fs = 1'b0;
        for (int c = 1; c <= end_c; c++) begin
            killed = (kill_c > 0) && (c > kill_c);
            if (rd_en && !prev_rd && nb < 16) begin
                obs_start[nb] = c;
                nb++;
            end
            prev_rd = rd_en;
            if (done) obs_done = c;
            chk("rd_en",      c, int'(rd_en),   killed ? 0 : int'(e_rd[c]));
            chk("rd_addr",    c, int'(rd_addr), killed ? 0 : e_addr[c]);
            chk("ifft_di_en", c, int'(di_en),   killed ? 0 : int'(e_rd[c-1]));
            chk("frame_busy", c, int'(busy),    killed ? 0 : int'(e_busy[c]));
            chk("frame_done", c, int'(done),    killed ? 0 : int'(e_done[c]));
            chk("underrun",   c, int'(und),
                killed ? (kill_rst ? 0 : int'(e_und[kill_c])) : int'(e_und[c]));
            if (!killed)       chk("sym_idx", c, int'(sym_idx), e_sym[c]);
            else if (kill_rst) chk("sym_idx", c, int'(sym_idx), 0);
            fs    = noise && (c < lim) && ($urandom_range(0, 7) == 0);
            sr    = ready_q[c];
            ab    = (c == kill_c) && !kill_rst;
            reset = (c == kill_c) && kill_rst;
            @(posedge clk); #1;
        end
        fs = 1'b0; ab = 1'b0; reset = 1'b0; sr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog cyc=0 got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fs = 1'b0; ab = 1'b0; sr = 1'b0; fs2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rd_en",   0, int'(rd_en),   0);
        chk("rst_rd_addr", 0, int'(rd_addr), 0);
        chk("rst_di_en",   0, int'(di_en),   0);
        chk("rst_sym_idx", 0, int'(sym_idx), 0);
        chk("rst_busy",    0, int'(busy),    0);
        chk("rst_done",    0, int'(done),    0);
        chk("rst_underrun",0, int'(und),     0);

        vt[0] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        vt[1] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[2] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[3] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[4] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        vt[5] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        vt[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vt[7] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            fs = vt[i].fs; ab = vt[i].ab; sr = vt[i].sr;
            @(posedge clk); #1;
            chk("vec_busy",     i, int'(busy),    int'(vt[i].e_busy));
            chk("vec_rd_en",    i, int'(rd_en),   int'(vt[i].e_rd));
            chk("vec_di_en",    i, int'(di_en),   int'(vt[i].e_di));
            chk("vec_rd_addr",  i, int'(rd_addr), vt[i].e_addr);
            chk("vec_done",     i, int'(done),    int'(vt[i].e_done));
            chk("vec_underrun", i, int'(und),     int'(vt[i].e_und));
        end
        fs = 1'b0; ab = 1'b0; sr = 1'b0;
        @(posedge clk); #1;

        fill_ready(0);
        run_frame(0, 1'b0, 1'b1);
        for (int k = 0; k < S; k++) chk("nom_burst_start", k, obs_start[k], 2 + 81 * k);
        chk("nom_bursts", 0, nb, 8);
        chk("nom_done_cycle", 0, obs_done, 633);

        fill_ready(1);
        run_frame(0, 1'b0, 1'b0);
        chk("urun_burst2_start", 0, obs_start[2], 164);
        chk("urun_burst3_start", 0, obs_start[3], 255);
        chk("urun_done_cycle", 0, obs_done, 643);
        chk("urun_flag_held", 0, int'(und), 1);

        fill_ready(0);
        run_frame(2 + 81 * 4 + 30, 1'b0, 1'b0);
        chk("abort_no_done", 0, obs_done, 0);
        chk("abort_bursts", 0, nb, 5);

        fill_ready(0);
        run_frame(0, 1'b0, 1'b0);
        chk("post_abort_done_cycle", 0, obs_done, 633);

        fill_ready(0);
        run_frame(2 + 81 + 64 + 5, 1'b1, 1'b0);
        chk("reset_bursts", 0, nb, 2);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
            fill_ready(2);
            run_frame(0, 1'b0, 1'b1);
        end

        fs2 = 1'b1;
        @(posedge clk); #1;
        fs2 = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            chk("short_rd_en",   c, int'(rd_en2),   (c >= 2 && c <= 65) ? 1 : 0);
            chk("short_rd_addr", c, int'(rd_addr2), (c >= 2 && c <= 65) ? c - 2 : 0);
            chk("short_di_en",   c, int'(di_en2),   (c >= 3 && c <= 66) ? 1 : 0);
            chk("short_done",    c, int'(done2),    (c == 66) ? 1 : 0);
            chk("short_busy",    c, int'(busy2),    (c <= 66) ? 1 : 0);
            chk("short_sym_idx", c, int'(sym_idx2), 0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofdm_sym_sched.md
# ofdm_sym_sched

Symbol scheduler for the OFDM transmit chain. It sits between the subcarrier staging buffer (filled from the modulator) and the 64-point IFFT. Once a frame is started, it reads one 64-sample symbol at a time from the buffer and forwards each as a contiguous IFFT input burst. Between bursts it inserts a fixed idle gap so the downstream cyclic-prefix stage (64 in, 80 out) never overflows, and it tracks symbol and frame boundaries.

## Interface
Parameters:
- N_FFT, 64, samples per symbol; power of two
- GAP, 16, idle cycles between symbol bursts; 0 allowed
- SYMS, 8, symbols per frame; ≥1

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle pulse; starts a frame; acted on only in IDLE
- abort  in  1  aborts the current frame
- sym_ready  in  1  buffer holds a complete symbol
- rd_en  out  1  buffer read strobe
- rd_addr  out  log2(N_FFT)  sample index
- ifft_di_en  out  1  IFFT input valid; rd_en delayed one cycle to match the buffer's 1-cycle read latency
- sym_idx  out  max(1,log2(SYMS))  index of the current symbol
- frame_busy  out  1  frame in progress
- frame_done  out  1  single-cycle completion pulse
- underrun  out  1  sticky stall flag

All outputs are registered. All outputs reset to 0.

## Operation
- States: IDLE, WAIT, READ, GAP, DONE. Reset state is IDLE.
- IDLE:
  - On frame_start=1 and abort=0: go to WAIT, set sym_idx=0, set frame_busy=1, clear underrun.
- WAIT:
  - On sym_ready=1: go to READ with rd_addr=0.
  - Otherwise stay in WAIT.
  - If sym_ready=0 while sym_idx>0, set underrun. This is the mid-frame starvation case.
- READ:
  - rd_en=1 and rd_addr increments by 1 each cycle.
  - On the rd_addr=N_FFT-1 cycle:
    - If sym_idx=SYMS-1: go to DONE.
    - Else if GAP>0: go to GAP with the gap counter at 0.
    - Else (GAP=0): increment sym_idx and go to WAIT.
- GAP:
  - rd_en=0 for exactly GAP cycles.
  - On the last GAP cycle: increment sym_idx and go to WAIT.
- DONE:
  - frame_done=1 for one cycle.
  - Next state is IDLE; frame_busy=0 from the next cycle.
- sym_ready is sampled only in WAIT. It is ignored during READ, GAP and DONE.
- frame_start is ignored while frame_busy=1.
- abort is honoured in any state and takes priority over every other input except reset.
  - Next cycle: IDLE, with rd_en=0, ifft_di_en=0, frame_busy=0 and rd_addr=0.
  - The in-flight burst is truncated.
  - frame_done is not pulsed.
  - underrun is held.
- abort and frame_start in the same cycle in IDLE: stay in IDLE.
- rd_addr wraps naturally at N_FFT-1 → 0. No other wrap exists.
- sym_idx never exceeds SYMS-1.

## Timing
- frame_start sampled at edge t → WAIT during cycle t+1.
- If sym_ready=1 in that cycle: READ during cycles t+2 … t+N_FFT+1, and ifft_di_en is high during t+3 … t+N_FFT+2.
- Steady-state symbol period with sym_ready always high: N_FFT+GAP+1 cycles (81 for the defaults). The +1 is the single WAIT cycle.
- With defaults and sym_ready always high:
  - Burst k starts at t+2+81k.
  - frame_done is high during cycle t+633.
  - frame_busy falls at t+634.
- ifft_di_en always lags rd_en by exactly one cycle. The only exceptions are abort and reset, which clear both in the same cycle.
- Underrun stall: each extra WAIT cycle delays every later burst by one cycle. Burst length stays N_FFT.

## Structure
- Shared package ofdm_ctrl_pkg contains:
  - the state enum (IDLE/WAIT/READ/GAP/DONE);
  - default constants OFDM_N_FFT=64 and OFDM_CP_LEN=16 (GAP defaults to OFDM_CP_LEN);
  - the symbols-per-frame default.
- Single flat module. The counters (rd_addr, gap, sym_idx) are simple enough that no sub-module is warranted.

## Test plan
- Nominal frame: sym_ready tied 1, frame_start pulse at t:
  - 8 bursts of 64 rd_en cycles with rd_addr 0..63 each;
  - 17 idle cycles between bursts (16 GAP + 1 WAIT);
  - frame_done at t+633;
  - ifft_di_en equals rd_en delayed one cycle throughout.
- Underrun: drop sym_ready for 10 cycles after burst 2 → underrun=1 and burst 3 starts 10 cycles late. The next accepted frame_start clears underrun.
- Abort mid-burst: abort at rd_addr=30 of burst 4:
  - next cycle IDLE with rd_en=0, ifft_di_en=0, frame_busy=0;
  - no frame_done;
  - a new frame_start then runs normally.
- Ignored/colliding inputs:
  - frame_start pulsed during a frame → no effect on sym_idx or timing;
  - frame_start+abort together in IDLE → stays IDLE.
- Reset mid-GAP: all outputs 0 next cycle and state IDLE; sym_ready=1 alone produces no rd_en.
- GAP=0, SYMS=1 build: a single 64-cycle burst, then frame_done one cycle after rd_addr=63.
